ins_seq_ctrl: RTL
=================

// Module: ins_seq_ctrl
// PURPOSE
//  Multi-cycle sequencer for the RV32I core: owns the PC and drives instruction-memory fetch.
//  Holds the fetched word in an instruction register that feeds the instruction decoder.
//  Takes the decoder's op and rd fields back and steps the datapath through
//  FETCH/DECODE/EXEC/MEM/WB using the memory req/ack handshakes.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC loaded on reset; first fetch address
//  NOP_INS   32'h0000_0013  ins register reset value (addi x0,x0,0)
// PORTS
//  clk         in   1   single clock, rising edge
//  rst         in   1   asynchronous, active-high reset
//  imem_req    out  1   fetch request, high in FETCH
//  imem_addr   out  32  fetch address (= pc)
//  imem_ack    in   1   fetch done; imem_rdata valid this cycle
//  imem_rdata  in   32  fetched instruction
//  ins         out  32  instruction register, to decoder
//  op          in   7   decoder opcode field
//  rd          in   5   decoder rd field
//  br_taken    in   1   branch condition from ALU, valid in EXEC
//  tgt         in   32  branch/jump target from datapath, valid in EXEC/WB
//  ex_en       out  1   ALU/operand latch strobe, high in EXEC
//  dmem_req    out  1   data-memory request, high in MEM
//  dmem_we     out  1   store when 1, load when 0; qualified by dmem_req
//  dmem_ack    in   1   data access done
//  rf_we       out  1   register-file write, high in WB when rd != 0
//  pc          out  32  current PC
//  state       out  3   FSM state, for debug
//  ill_ins     out  1   illegal-instruction flag (ILLEGAL_TRAP_EN only)
// BEHAVIOUR
//  Reset (async): state=FETCH, pc=RESET_PC, ins=NOP_INS. Strobes follow from FETCH state;
//  only imem_req=1, all others 0.
//  Moore outputs: all strobes decode from state only. State enc: FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 TRAP=5.
//  FETCH:  imem_req=1, imem_addr=pc held stable until imem_ack is sampled high.
//          On ack: ins<=imem_rdata, ->DECODE. No abandon; ack allowed in the same cycle as req.
//  DECODE: 1 cycle; classify op. ->EXEC, or ->TRAP when illegal and macro defined.
//  EXEC:   ex_en=1 for 1 cycle.
//          LOAD(0000011)/STORE(0100011) ->MEM.
//          BRANCH(1100011): pc<=br_taken?tgt:pc+4, ->FETCH.
//          OP, OP_IMM, LUI, AUIPC, JAL, JALR ->WB.
//          MISC_MEM(0001111), SYSTEM(1110011): pc<=pc+4, ->FETCH (NOP).
//  MEM:    dmem_req=1, dmem_we=(op==STORE), held until dmem_ack.
//          On ack: STORE pc<=pc+4 ->FETCH; LOAD ->WB.
//  WB:     rf_we=(rd!=0) for 1 cycle. pc<=(JAL|JALR)?tgt:pc+4, ->FETCH.
//  PC loads force bits [1:0] to 00; pc+4 wraps modulo 2^32.
//  Zero-wait latency: ALU op 4 cycles, branch 3, load 5, store 4.
//  Illegal: op not in the list above, or ins[1:0]!=2'b11.
//  Reset mid-transaction: req drops at once; memories must drop ack with rst.
//  ins, op and rd stay stable from DECODE through WB.
// CONFIGURATION
//  ILLEGAL_TRAP_EN defined: illegal -> TRAP. TRAP is sticky; only rst exits.
//    In TRAP: ill_ins=1, all strobes 0, pc holds the faulting address.
//  Undefined: ill_ins tied 0 and TRAP unreachable.
//    Illegal instructions go through EXEC as NOP: pc<=pc+4, no rf_we, no dmem_req.
// STRUCTURE
//  Shared package rv_pkg: opcode localparams (OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE,
//  OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC, OPC_MISC_MEM, OPC_SYSTEM), state encodings.
//  Sub-module ins_class: combinational op -> {is_mem, is_store, is_br, is_jmp, is_wb, is_nop, is_ill}.
//  Top holds the FSM, pc and ins registers.
// TESTING
//  1 RESET_PC=0x100, release rst -> imem_req=1, imem_addr=0x100, state=0, rf_we=dmem_req=ex_en=0.
//  2 add 0x003100B3, ack same cycle -> states 0,1,2,4,0; rf_we high only in WB; next imem_addr=0x104.
//  3 sw 0xAA20A523, dmem_ack after 3 cycles -> dmem_req=dmem_we=1 for 3 cycles; rf_we never; pc+4.
//  4 bgeu 0xD420FA63: br_taken=1,tgt=0x2000 -> next fetch 0x2000; br_taken=0 -> pc+4; no WB state.
//  5 jal x1 0xD54550EF, tgt=0x80 -> rf_we=1 in WB, next fetch 0x80; rd=0 variant -> rf_we=0.
//  6 ins 0x00000000: macro on -> ill_ins=1, state=5, imem_req=0 for 10+ cycles; off -> pc+4, no rf_we.
//    Also: rst during MEM -> dmem_req=0 at once, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32I definitions: opcode values, sequencer state encoding and the
// instruction-class bundle passed from ins_class to the sequencer.
package rv_pkg;

   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   localparam logic [31:0] PC_STEP = 32'd4;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_TRAP   = 3'd5
   } state_t;

   typedef struct packed {
      logic is_mem;
      logic is_store;
      logic is_br;
      logic is_jmp;
      logic is_wb;
      logic is_nop;
      logic is_ill;
   } ins_cls_t;

   // Every PC load is word aligned; the low two bits are always dropped.
   function automatic logic [31:0] pc_align(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/ins_class.sv
// Combinational opcode classifier for the sequencer. An illegal encoding
// (unknown opcode or ins[1:0] != 2'b11) clears every other class flag.
module ins_class
   import rv_pkg::*;
(
   input  logic [6:0] op,
   input  logic [1:0] ins_lo,
   output ins_cls_t   cls
);

   ins_cls_t raw;
   logic     legal;

   always_comb begin
      raw   = '0;
      legal = 1'b1;
      case (op)
         OPC_LOAD: begin
            raw.is_mem = 1'b1;
            raw.is_wb  = 1'b1;
         end
         OPC_STORE: begin
            raw.is_mem   = 1'b1;
            raw.is_store = 1'b1;
         end
         OPC_BRANCH:                   raw.is_br  = 1'b1;
         OPC_JAL, OPC_JALR: begin
            raw.is_jmp = 1'b1;
            raw.is_wb  = 1'b1;
         end
         OPC_OP, OPC_OP_IMM,
         OPC_LUI, OPC_AUIPC:           raw.is_wb  = 1'b1;
         OPC_MISC_MEM, OPC_SYSTEM:     raw.is_nop = 1'b1;
         default:                      legal      = 1'b0;
      endcase
   end

   always_comb begin
      cls = raw;
      if (!legal || (ins_lo != 2'b11)) begin
         cls        = '0;
         cls.is_ill = 1'b1;
      end
   end

endmodule

// File: rtl/ins_seq_ctrl.sv
// Multi-cycle RV32I sequencer: PC, fetch handshake, instruction register and
// FETCH/DECODE/EXEC/MEM/WB stepping. ILLEGAL_TRAP_EN enables the sticky TRAP state.
//
// state  | meaning
// FETCH  | imem_req high, waiting for imem_ack; ins loads on ack
// DECODE | one cycle for the decoder to settle op/rd
// EXEC   | ex_en strobe; branches and NOPs resolve the PC here
// MEM    | dmem_req held until dmem_ack
// WB     | rf_we when rd != 0; PC advances or jumps
// TRAP   | illegal instruction seen, all strobes low until rst
module ins_seq_ctrl
   import rv_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INS  = 32'h0000_0013
)(
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] ins,
   input  logic [6:0]  op,
   input  logic [4:0]  rd,
   input  logic        br_taken,
   input  logic [31:0] tgt,
   output logic        ex_en,
   output logic        dmem_req,
   output logic        dmem_we,
   input  logic        dmem_ack,
   output logic        rf_we,
   output logic [31:0] pc,
   output logic [2:0]  state,
   output logic        ill_ins
);

   state_t      st, st_nxt;
   ins_cls_t    cls;
   logic        pc_ld;
   logic [31:0] pc_nxt;
   logic [31:0] pc_inc;

   ins_class u_ins_class (
      .op     (op),
      .ins_lo (ins[1:0]),
      .cls    (cls)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) st <= ST_FETCH;
      else     st <= st_nxt;
   end

   always_comb begin
      st_nxt = st;
      case (st)
         ST_FETCH:  if (imem_ack) st_nxt = ST_DECODE;
`ifdef ILLEGAL_TRAP_EN
         ST_DECODE: st_nxt = cls.is_ill ? ST_TRAP : ST_EXEC;
`else
         ST_DECODE: st_nxt = ST_EXEC;
`endif
         ST_EXEC: begin
            if (cls.is_mem)     st_nxt = ST_MEM;
            else if (cls.is_wb) st_nxt = ST_WB;
            else                st_nxt = ST_FETCH;
         end
         ST_MEM:    if (dmem_ack) st_nxt = cls.is_store ? ST_FETCH : ST_WB;
         ST_WB:     st_nxt = ST_FETCH;
         ST_TRAP:   st_nxt = ST_TRAP;
         default:   st_nxt = ST_FETCH;
      endcase
   end

   always_comb begin
      imem_req = (st == ST_FETCH);
      ex_en    = (st == ST_EXEC);
      dmem_req = (st == ST_MEM);
      dmem_we  = (st == ST_MEM) && cls.is_store;
      rf_we    = (st == ST_WB) && (rd != 5'd0);
`ifdef ILLEGAL_TRAP_EN
      ill_ins  = (st == ST_TRAP);
`else
      ill_ins  = 1'b0;
`endif
   end

   assign state     = st;
   assign imem_addr = pc;
   assign pc_inc    = pc + PC_STEP;

   // Illegal ops only reach EXEC when trapping is off; they retire as NOPs.
   always_comb begin
      pc_ld  = 1'b0;
      pc_nxt = pc_inc;
      case (st)
         ST_EXEC: begin
            if (cls.is_br) begin
               pc_ld  = 1'b1;
               pc_nxt = br_taken ? tgt : pc_inc;
            end else if (cls.is_nop || cls.is_ill) begin
               pc_ld  = 1'b1;
            end
         end
         ST_MEM:  pc_ld = dmem_ack && cls.is_store;
         ST_WB: begin
            pc_ld = 1'b1;
            if (cls.is_jmp) pc_nxt = tgt;
         end
         default: pc_ld = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)        pc <= RESET_PC;
      else if (pc_ld) pc <= pc_align(pc_nxt);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                              ins <= NOP_INS;
      else if ((st == ST_FETCH) && imem_ack) ins <= imem_rdata;
   end

endmodule
